// File: rtl/insn_ctrl_fsm.sv
// Multi-cycle MIPS-style instruction control FSM (IF/ID/EXE/MEM/WB) driving datapath strobes and mux selects.
// Optional retired-instruction counter output insn_count is built only when INSN_COUNT_EN is defined.
module insn_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_sel,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_src,
  output logic [5:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal
`ifdef INSN_COUNT_EN
  ,
  output logic [31:0] insn_count
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUBU = 6'b100011;

  state_e state_q, state_d;
  logic pc_we_s, ir_we_s, mem_re_s, mem_we_s, reg_we_s, illegal_s;
  logic is_r_s, is_jr_s, is_j_s, is_jal_s, is_ialu_s, is_lw_s, is_sw_s, is_br_s, is_legal_s;

  function automatic logic [5:0] ialu_op(input logic [5:0] opc);
    case (opc)
      6'b001000, 6'b001001: ialu_op = 6'b100000;
      6'b001010:            ialu_op = 6'b101010;
      6'b001011:            ialu_op = 6'b101011;
      6'b001100:            ialu_op = 6'b110100;
      6'b001101:            ialu_op = 6'b110101;
      6'b001110:            ialu_op = 6'b110110;
      6'b001111:            ialu_op = 6'b110000;
      default:              ialu_op = 6'b000000;
    endcase
  endfunction

  assign is_r_s     = (opcode == 6'b000000);
  assign is_jr_s    = is_r_s && (funct == 6'b001000);
  assign is_j_s     = (opcode == 6'b000010);
  assign is_jal_s   = (opcode == 6'b000011);
  assign is_ialu_s  = (opcode[5:3] == 3'b001);
  assign is_lw_s    = (opcode == 6'b100011);
  assign is_sw_s    = (opcode == 6'b101011);
  assign is_br_s    = (opcode == 6'b000100) || (opcode == 6'b000101);
  assign is_legal_s = is_r_s | is_j_s | is_jal_s | is_ialu_s | is_lw_s | is_sw_s | is_br_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    pc_we_s   = 1'b0;
    ir_we_s   = 1'b0;
    mem_re_s  = 1'b0;
    mem_we_s  = 1'b0;
    reg_we_s  = 1'b0;
    illegal_s = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    ext_sel   = 1'b0;
    reg_dst   = 2'b00;
    wb_sel    = 2'b00;
    pc_src    = 2'b00;
    alu_op    = 6'b000000;
    case (state_q)
      S_IF: begin
        mem_re_s  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = OP_ADDU;
        if (mem_ready) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
          state_d = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        // ALU precomputes the branch target while the instruction is decoded
        alu_src_b = 2'b11;
        ext_sel   = 1'b1;
        alu_op    = OP_ADDU;
        if (is_j_s) begin
          pc_we_s = 1'b1;
          pc_src  = 2'b10;
          state_d = S_IF;
        end else if (is_jal_s) begin
          pc_we_s  = 1'b1;
          pc_src   = 2'b10;
          reg_we_s = 1'b1;
          reg_dst  = 2'b10;
          wb_sel   = 2'b10;
          state_d  = S_IF;
        end else if (is_jr_s) begin
          pc_we_s = 1'b1;
          pc_src  = 2'b11;
          state_d = S_IF;
        end else if (!is_legal_s) begin
          illegal_s = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_r_s) begin
          alu_op    = funct;
          alu_src_a = ((funct == 6'b000000) || (funct == 6'b000010) || (funct == 6'b000011)) ? 2'b10 : 2'b01;
          state_d   = S_WB;
        end else if (is_ialu_s) begin
          alu_op    = ialu_op(opcode);
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          ext_sel   = !((opcode == 6'b001100) || (opcode == 6'b001101) || (opcode == 6'b001110));
          state_d   = S_WB;
        end else if (is_lw_s || is_sw_s) begin
          alu_op    = OP_ADDU;
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          ext_sel   = 1'b1;
          state_d   = S_MEM;
        end else if (is_br_s) begin
          alu_op    = OP_SUBU;
          alu_src_a = 2'b01;
          pc_src    = 2'b01;
          pc_we_s   = opcode[0] ? !zero : zero;
          state_d   = S_IF;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (is_lw_s) begin
          mem_re_s = 1'b1;
          state_d  = mem_ready ? S_WB : S_MEM;
        end else if (is_sw_s) begin
          mem_we_s = 1'b1;
          state_d  = mem_ready ? S_IF : S_MEM;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        reg_we_s = 1'b1;
        if (is_r_s) begin
          reg_dst = 2'b01;
        end else if (is_lw_s) begin
          wb_sel = 2'b01;
        end else begin
          reg_dst = 2'b00;
        end
        state_d = S_IF;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Reset masks every strobe at once, independent of what IF would decode
  assign pc_we   = pc_we_s   & rst_n;
  assign ir_we   = ir_we_s   & rst_n;
  assign mem_re  = mem_re_s  & rst_n;
  assign mem_we  = mem_we_s  & rst_n;
  assign reg_we  = reg_we_s  & rst_n;
  assign illegal = illegal_s & rst_n;
  assign state   = state_q;

`ifdef INSN_COUNT_EN
  logic [31:0] count_q, count_d;

  assign count_d = ((state_q != S_IF) && (state_d == S_IF)) ? count_q + 32'd1 : count_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign insn_count = count_q;
`endif

endmodule

// File: tb/tb_insn_ctrl_fsm.sv
// Randomized self-checking bench for insn_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle outputs, which are compared against the DUT.
module tb_insn_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, mem_re, mem_we, reg_we, ext_sel, illegal;
  logic [1:0] alu_src_a, alu_src_b, reg_dst, wb_sel, pc_src;
  logic [5:0] alu_op;
  logic [2:0] state;
`ifdef INSN_COUNT_EN
  logic [31:0] insn_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cnt_m = 32'd0;

  typedef enum int {C_J, C_JAL, C_JR, C_R, C_I, C_LW, C_SW, C_BR, C_ILL} cls_e;

  typedef struct packed {
    logic [2:0] st;
    logic       mr;
    logic       last;
    logic       pc_we, ir_we, mem_re, mem_we, reg_we;
    logic [1:0] a, b;
    logic       ext;
    logic [1:0] dst, wb, pcs;
    logic [5:0] op;
    logic       ill;
  } cyc_t;

  cyc_t q[$];

  insn_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .pc_src(pc_src), .alu_op(alu_op), .state(state), .illegal(illegal)
`ifdef INSN_COUNT_EN
    , .insn_count(insn_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cls_e classify(input logic [5:0] opc, input logic [5:0] fn);
    case (opc)
      6'h00:   return (fn == 6'h08) ? C_JR : C_R;
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      6'h04, 6'h05: return C_BR;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return C_I;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      default: return C_ILL;
    endcase
  endfunction

  // Expand one instruction into its expected cycle sequence
  task automatic gen(input logic [5:0] opc, input logic [5:0] fn, input logic z, input int wif, input int wmem);
    cls_e c = classify(opc, fn);
    cyc_t r;
    for (int i = 0; i <= wif; i++) begin
      r = '0; r.st = 3'd0; r.mem_re = 1'b1; r.b = 2'd1; r.op = 6'd33;
      r.mr = (i == wif);
      r.pc_we = r.mr; r.ir_we = r.mr;
      q.push_back(r);
    end
    r = '0; r.st = 3'd1; r.b = 2'd3; r.ext = 1'b1; r.op = 6'd33; r.mr = 1'($urandom_range(0, 1));
    case (c)
      C_J:   begin r.pc_we = 1'b1; r.pcs = 2'd2; end
      C_JAL: begin r.pc_we = 1'b1; r.pcs = 2'd2; r.reg_we = 1'b1; r.dst = 2'd2; r.wb = 2'd2; end
      C_JR:  begin r.pc_we = 1'b1; r.pcs = 2'd3; end
      C_ILL: r.ill = 1'b1;
      default: ;
    endcase
    if (c inside {C_J, C_JAL, C_JR, C_ILL}) begin
      r.last = 1'b1; q.push_back(r); return;
    end
    q.push_back(r);
    r = '0; r.st = 3'd2; r.mr = 1'($urandom_range(0, 1));
    case (c)
      C_R: begin r.op = fn; r.a = (fn == 6'd0 || fn == 6'd2 || fn == 6'd3) ? 2'd2 : 2'd1; end
      C_I: begin
        r.a = 2'd1; r.b = 2'd2;
        r.ext = !(opc == 6'h0C || opc == 6'h0D || opc == 6'h0E);
        case (opc)
          6'h0A: r.op = 6'h2A;
          6'h0B: r.op = 6'h2B;
          6'h0C: r.op = 6'h34;
          6'h0D: r.op = 6'h35;
          6'h0E: r.op = 6'h36;
          6'h0F: r.op = 6'h30;
          default: r.op = 6'h20;
        endcase
      end
      C_BR: begin r.op = 6'h23; r.a = 2'd1; r.pcs = 2'd1; r.pc_we = (opc == 6'h04) ? z : !z; r.last = 1'b1; end
      default: begin r.op = 6'd33; r.a = 2'd1; r.b = 2'd2; r.ext = 1'b1; end
    endcase
    q.push_back(r);
    if (c == C_BR) return;
    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i <= wmem; i++) begin
        r = '0; r.st = 3'd3; r.mr = (i == wmem);
        r.mem_re = (c == C_LW); r.mem_we = (c == C_SW);
        r.last = (c == C_SW) && r.mr;
        q.push_back(r);
      end
      if (c == C_SW) return;
    end
    r = '0; r.st = 3'd4; r.reg_we = 1'b1; r.last = 1'b1; r.mr = 1'($urandom_range(0, 1));
    if (c == C_R) r.dst = 2'd1;
    if (c == C_LW) r.wb = 2'd1;
    q.push_back(r);
  endtask

  task automatic check_reset();
    check_val("rst_state", {29'd0, state}, 32'd0);
    check_val("rst_strobes", {26'd0, pc_we, ir_we, mem_re, mem_we, reg_we, illegal}, 32'd0);
`ifdef INSN_COUNT_EN
    check_val("rst_count", insn_count, 32'd0);
`endif
  endtask

  task automatic run_insn(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                          input int wif, input int wmem, input bit abort_in_mem);
    cyc_t r;
    q.delete();
    gen(opc, fn, z, wif, wmem);
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      opcode = opc; funct = fn; zero = z; mem_ready = r.mr;
      #1;
      check_val("state", {29'd0, state}, {29'd0, r.st});
      check_val("outs",
        {9'd0, pc_we, ir_we, mem_re, mem_we, reg_we, alu_src_a, alu_src_b, ext_sel, reg_dst, wb_sel, pc_src, alu_op, illegal},
        {9'd0, r.pc_we, r.ir_we, r.mem_re, r.mem_we, r.reg_we, r.a, r.b, r.ext, r.dst, r.wb, r.pcs, r.op, r.ill});
`ifdef INSN_COUNT_EN
      check_val("count", insn_count, cnt_m);
`endif
      if (r.last) cnt_m = cnt_m + 32'd1;
      if (abort_in_mem && r.st == 3'd3) begin
        rst_n = 1'b0;
        #1;
        check_reset();
        cnt_m = 32'd0;
        @(negedge clk);
        #1;
        check_reset();
        mem_ready = 1'b0;
        rst_n = 1'b1;
        q.delete();
      end
    end
  endtask

  initial begin
    logic [5:0] legal_ops [15];
    logic [5:0] opc, fn;
    legal_ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                  6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset();
    mem_ready = 1'b0;
    rst_n = 1'b1;

    run_insn(6'h00, 6'h21, 1'b0, 0, 0, 1'b0);   // addu
    run_insn(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);   // lw, memory slow
    run_insn(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);   // beq taken
    run_insn(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);   // beq not taken
    run_insn(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);   // bne
    run_insn(6'h05, 6'h00, 1'b0, 1, 0, 1'b0);
    run_insn(6'h00, 6'h00, 1'b0, 0, 0, 1'b0);   // sll
    run_insn(6'h0C, 6'h00, 1'b0, 0, 0, 1'b0);   // andi
    run_insn(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);   // undecoded
    run_insn(6'h00, 6'h08, 1'b0, 2, 0, 1'b0);   // jr
    run_insn(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);   // jal
    run_insn(6'h2B, 6'h00, 1'b0, 1, 2, 1'b0);   // sw

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) != 0) opc = legal_ops[$urandom_range(0, 14)];
      else opc = 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 7) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
      run_insn(opc, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

`ifdef INSN_COUNT_EN
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    cnt_m = 32'hFFFF_FFFF;
    #1;
    check_val("count_preload", insn_count, 32'hFFFF_FFFF);
    run_insn(6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    run_insn(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
`endif

    run_insn(6'h2B, 6'h00, 1'b0, 0, 5, 1'b1);   // sw aborted by reset in MEM
    run_insn(6'h00, 6'h21, 1'b0, 1, 0, 1'b0);
    run_insn(6'h23, 6'h00, 1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/insn_ctrl_fsm.md
INSN_CTRL_FSM -- requirements
Module: insn_ctrl_fsm

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock.
REQ-002 SHALL provide: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: opcode  in  6  IR[31:26].
REQ-004 SHALL provide: funct  in  6  IR[5:0].
REQ-005 SHALL provide: zero  in  1  ALU result == 0.
REQ-006 SHALL provide: mem_ready  in  1  memory access complete this cycle.
REQ-007 SHALL provide: pc_we, ir_we, mem_re, mem_we, reg_we  out  1 each  write/read strobes.
REQ-008 SHALL provide: alu_src_a  out  2  operand A: 00 PC, 01 rs, 10 zero-extended shamt.
REQ-009 SHALL provide: alu_src_b  out  2  operand B: 00 rt, 01 constant 4, 10 ext imm, 11 ext imm<<2.
REQ-010 SHALL provide: ext_sel  out  1  1 sign-extend, 0 zero-extend.
REQ-011 SHALL provide: reg_dst  out  2  00 rt, 01 rd, 10 $31.
REQ-012 SHALL provide: wb_sel  out  2  00 ALU result, 01 memory data, 10 PC.
REQ-013 SHALL provide: pc_src  out  2  00 ALU result, 01 latched ALU out, 10 jump target, 11 rs.
REQ-014 SHALL provide: alu_op  out  6  ALU operation code.
REQ-015 SHALL provide: state  out  3  current state; illegal  out  1  one-cycle pulse for an undecoded instruction.

Function
REQ-016 States: IF=0, ID=1, EXE=2, MEM=3, WB=4; state is registered; all other outputs decode combinationally from state, opcode and funct.
REQ-017 IF: mem_re=1, alu_src_a=00, alu_src_b=01, alu_op=100001; ir_we and pc_we pulse only in the cycle mem_ready=1, then go to ID; otherwise stay in IF.
REQ-018 ID: alu_src_a=00, alu_src_b=11, ext_sel=1, alu_op=100001 (branch target); j -> pc_we=1, pc_src=10, go to IF.
REQ-019 ID jal (000011): pc_we=1, pc_src=10, reg_we=1, reg_dst=10, wb_sel=10, go to IF.
REQ-020 ID jr (opcode 000000, funct 001000): pc_we=1, pc_src=11, go to IF.
REQ-021 ID unsupported opcode: illegal=1, go to IF, no write strobes.
REQ-022 EXE R-type: alu_op=funct, alu_src_b=00; alu_src_a=10 for funct 000000/000010/000011, else 01; go to WB.
REQ-023 EXE I-type ALU: alu_src_a=01, alu_src_b=10; alu_op: addi/addiu 100000, slti 101010, sltiu 101011, andi 110100, ori 110101, xori 110110, lui 110000; ext_sel=0 for andi/ori/xori, else 1; go to WB.
REQ-024 EXE lw/sw (100011/101011): alu_op=100001, alu_src_a=01, alu_src_b=10, ext_sel=1; go to MEM.
REQ-025 EXE beq/bne (000100/000101): alu_op=100011, alu_src_a=01, alu_src_b=00, pc_src=01; pc_we=zero (beq) or ~zero (bne); go to IF.
REQ-026 MEM: lw mem_re=1, sw mem_we=1, held until mem_ready=1; lw then WB, sw then IF.
REQ-027 WB: reg_we=1; R-type reg_dst=01, wb_sel=00; I-type ALU reg_dst=00, wb_sel=00; lw reg_dst=00, wb_sel=01; go to IF.
REQ-028 Cycle counts with mem_ready always 1: j/jal/jr 2, beq/bne 3, R/I-ALU/sw 4, lw 5.
REQ-029 Any undriven output in a state SHALL be 0.

Reset
REQ-030 rst_n low SHALL immediately force state=IF and hold all write/read strobes, illegal and insn_count at 0 regardless of state decode.
REQ-031 Reset deassertion: first IF fetch begins on the next rising edge; reset mid-instruction aborts it with no further strobes.

Configuration
REQ-032 Macro INSN_COUNT_EN defined: output insn_count (32 bits) increments on every transition into IF from ID/EXE/MEM/WB, wraps 0xFFFFFFFF->0, resets to 0.
REQ-033 Macro INSN_COUNT_EN undefined: insn_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-034 addu (opcode 0, funct 100001), mem_ready=1 -> states 0,1,2,4,0; alu_op=100001 in EXE; reg_we=1, reg_dst=01 in WB.
REQ-035 lw with mem_ready low 3 cycles in MEM -> mem_re held 4 cycles, WB wb_sel=01, total 8 cycles.
REQ-036 beq with zero=1 -> pc_we=1, pc_src=01 in EXE; zero=0 -> pc_we=0; bne inverts.
REQ-037 sll (funct 000000) -> alu_src_a=10; andi -> ext_sel=0, alu_op=110100; opcode 111111 -> illegal pulse in ID, return to IF.
REQ-038 rst_n low during MEM of sw -> mem_we=0 immediately, state=0; with INSN_COUNT_EN, count 0xFFFFFFFF + one instruction -> 0.
